// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory port.
package lsu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC0 = 2'b01,
    ACC1 = 2'b10,
    RESP = 2'b11
  } state_e;

  // Access width in bytes; the reserved encoding reports zero bytes.
  function automatic logic [2:0] size_nbytes(input size_e sz);
    case (sz)
      SZ_BYTE: size_nbytes = 3'd1;
      SZ_HALF: size_nbytes = 3'd2;
      SZ_WORD: size_nbytes = 3'd4;
      default: size_nbytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store data/strobe placement across two words and
// load extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e            size,
  input  logic [1:0]       off,
  input  logic             is_unsigned,
  input  logic [XLEN-1:0]  wdata,
  input  logic [XLEN-1:0]  lo,
  input  logic [XLEN-1:0]  hi,
  output logic [XLEN-1:0]  din_lo,
  output logic [XLEN-1:0]  din_hi,
  output logic [3:0]       we_lo,
  output logic [3:0]       we_hi,
  output logic [XLEN-1:0]  rdata
);

  logic [2*XLEN-1:0] st_shift;
  logic [2*XLEN-1:0] ld_shift;
  logic [7:0]        mask;
  logic [3:0]        base;
  logic [4:0]        bit_off;

  assign bit_off  = {off, 3'b000};
  assign st_shift = {{XLEN{1'b0}}, wdata} << bit_off;
  assign ld_shift = {hi, lo} >> bit_off;
  assign mask     = {4'b0000, base} << off;

  assign din_lo = st_shift[XLEN-1:0];
  assign din_hi = st_shift[2*XLEN-1:XLEN];
  assign we_lo  = mask[3:0];
  assign we_hi  = mask[7:4];

  // Byte strobe pattern for the access width before lane shifting.
  always_comb begin
    base = 4'b0000;
    case (size)
      SZ_BYTE: base = 4'b0001;
      SZ_HALF: base = 4'b0011;
      SZ_WORD: base = 4'b1111;
      default: base = 4'b0000;
    endcase
  end

  // Truncate the shifted load data to the access width and extend it.
  always_comb begin
    rdata = '0;
    case (size)
      SZ_BYTE: rdata = is_unsigned ? {24'h0, ld_shift[7:0]}
                                   : {{24{ld_shift[7]}}, ld_shift[7:0]};
      SZ_HALF: rdata = is_unsigned ? {16'h0, ld_shift[15:0]}
                                   : {{16{ld_shift[15]}}, ld_shift[15:0]};
      SZ_WORD: rdata = ld_shift[XLEN-1:0];
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Single-request load/store unit in front of a word-wide synchronous RAM port.
// Misaligned accesses that straddle a word boundary take two RAM cycles.
//
// state | meaning
// IDLE  | ready for a request
// ACC0  | RAM access to the first (or only) word
// ACC1  | RAM access to the second word of a split access
// RESP  | access done; response is registered out on the next edge
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter  int RAM_DEPTH = 8192,
  localparam int ADDR_W    = $clog2(RAM_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [31:0]       req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_din_o,
  input  logic [31:0]       mem_dout_i
);

  state_e state_q, state_d;

  logic              accept;
  size_e             req_size;
  logic [2:0]        req_nbytes;
  logic [32:0]       req_last;
  logic [3:0]        req_span;
  logic              req_split;
  logic              req_err;

  logic [ADDR_W+1:0] addr_q;
  size_e             size_q;
  logic              uns_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic              split_q;
  logic              err_q;
  logic [31:0]       lo_q;
  logic [31:0]       hi_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [31:0]       rsp_rdata_q;

  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       din_lo, din_hi, ld_rdata;
  logic [3:0]        we_lo, we_hi;

  // Decode of the incoming request; the last byte is computed one bit wider
  // so an address near 2^32 cannot wrap back into range.
  assign req_size   = size_e'(req_size_i);
  assign req_nbytes = size_nbytes(req_size);
  assign req_last   = {1'b0, req_addr_i} + {30'b0, req_nbytes} - 33'd1;
  assign req_span   = {2'b00, req_addr_i[1:0]} + {1'b0, req_nbytes};
  assign req_split  = req_span > 4'd4;
  assign req_err    = (req_size == SZ_RSVD) || (req_last[32:ADDR_W+2] != '0);

  assign req_ready_o = rst_ni && (state_q == IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign word_idx    = addr_q[ADDR_W+1:2];

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

  lsu_align u_align (
    .size        (size_q),
    .off         (addr_q[1:0]),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .lo          (lo_q),
    .hi          (split_q ? hi_q : 32'h0),
    .din_lo      (din_lo),
    .din_hi      (din_hi),
    .we_lo       (we_lo),
    .we_hi       (we_hi),
    .rdata       (ld_rdata)
  );

  // Next state and RAM port drive; the port is gated by rst_ni so a reset
  // landing mid-access never lets the in-flight write complete.
  always_comb begin
    state_d    = state_q;
    mem_en_o   = 1'b0;
    mem_we_o   = 4'b0000;
    mem_din_o  = 32'h0;
    mem_addr_o = mem_addr_q;
    case (state_q)
      IDLE: if (accept) state_d = req_err ? RESP : ACC0;
      ACC0: state_d = split_q ? ACC1 : RESP;
      ACC1: state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst_ni) begin
      if (state_q == ACC0) begin
        mem_en_o   = 1'b1;
        mem_addr_o = word_idx;
        mem_we_o   = we_q ? we_lo : 4'b0000;
        mem_din_o  = we_q ? din_lo : 32'h0;
      end else if (state_q == ACC1) begin
        mem_en_o   = 1'b1;
        mem_addr_o = word_idx + 1'b1;
        mem_we_o   = we_q ? we_hi : 4'b0000;
        mem_din_o  = we_q ? din_hi : 32'h0;
      end
    end
  end

  // State, captured request, read data and registered response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= 32'h0;
      split_q     <= 1'b0;
      err_q       <= 1'b0;
      lo_q        <= 32'h0;
      hi_q        <= 32'h0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_o;
      if (accept) begin
        addr_q  <= req_addr_i[ADDR_W+1:0];
        size_q  <= req_size;
        uns_q   <= req_unsigned_i;
        we_q    <= req_we_i;
        wdata_q <= req_wdata_i;
        split_q <= req_split;
        err_q   <= req_err;
      end
      if (state_q == ACC0) lo_q <= mem_dout_i;
      if (state_q == ACC1) hi_q <= mem_dout_i;
      rsp_valid_q <= (state_q == RESP);
      rsp_err_q   <= (state_q == RESP) && err_q;
      rsp_rdata_q <= ((state_q == RESP) && !err_q && !we_q) ? ld_rdata : 32'h0;
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a behavioural word RAM.
module tb_lsu_mem_port;

  localparam int RAM_DEPTH = 8192;
  localparam int ADDR_W    = $clog2(RAM_DEPTH);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [1:0]        req_size;
  logic              req_uns;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;

  logic [31:0] mem [0:RAM_DEPTH-1];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_mem_port #(.RAM_DEPTH(RAM_DEPTH)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_addr_i     (req_addr),
    .req_size_i     (req_size),
    .req_unsigned_i (req_uns),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .mem_en_o       (mem_en),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_din_o      (mem_din),
    .mem_dout_i     (mem_dout)
  );

  assign mem_dout = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request at a negedge; returns 1 time unit after the accepting edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_uns = uns; req_wdata = wdata;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL issue_ready addr=%h: got %b want 1", addr, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_en} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {req_ready, rsp_valid, rsp_err, mem_en});
    end
    n_checks++;
    if ({rsp_rdata, mem_din, mem_we} !== 68'h0) begin
      n_fail++; $display("FAIL reset_data: rdata=%h din=%h we=%b want 0", rsp_rdata, mem_din, mem_we);
    end
    n_checks++;
    if (mem_addr !== '0) begin
      n_fail++; $display("FAIL reset_addr: got %h want 0", mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_aligned_store();
    issue(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_din} !== {1'b1, 4'b1111, 13'd4, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL st_word_acc0: en=%b we=%b addr=%0d din=%h want 1 1111 4 deadbeef",
                         mem_en, mem_we, mem_addr, mem_din);
    end
    step();
    n_checks++;
    if ({mem_en, mem_we, mem_din, rsp_valid, req_ready} !== {1'b0, 4'b0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL st_word_resp_state: en=%b we=%b din=%h vld=%b rdy=%b want all 0",
                         mem_en, mem_we, mem_din, rsp_valid, req_ready);
    end
    n_checks++;
    if (mem_addr !== 13'd4) begin
      n_fail++; $display("FAIL st_word_addr_hold: got %0d want 4", mem_addr);
    end
    step();
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL st_word_rsp: vld=%b err=%b rdata=%h want 1 0 0", rsp_valid, rsp_err, rsp_rdata);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL st_word_rsp_pulse: got %b want 0", rsp_valid);
    end
    n_checks++;
    if (mem[4] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL st_word_mem: got %h want deadbeef", mem[4]);
    end
  endtask

  task automatic test_byte_load();
    logic [31:0] exp_rd [2];
    exp_rd[0] = 32'hFFFFFF80;
    exp_rd[1] = 32'h00000080;
    @(negedge clk);
    mem[4] = 32'h80112233;
    for (int u = 0; u < 2; u++) begin
      issue(1'b0, 32'h13, 2'b00, u[0], 32'hFFFFFFFF);
      n_checks++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 4'b0000, 13'd4}) begin
        n_fail++; $display("FAIL ld_byte_acc0 u=%0d: en=%b we=%b addr=%0d want 1 0000 4",
                           u, mem_en, mem_we, mem_addr);
      end
      step();
      step();
      n_checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, exp_rd[u]}) begin
        n_fail++; $display("FAIL ld_byte_rsp u=%0d: vld=%b err=%b rdata=%h want 1 0 %h",
                           u, rsp_valid, rsp_err, rsp_rdata, exp_rd[u]);
      end
    end
  endtask

  task automatic test_split_store();
    @(negedge clk);
    mem[2] = 32'h11111111;
    mem[3] = 32'h22222222;
    issue(1'b1, 32'h0B, 2'b01, 1'b0, 32'h0000A1B2);
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_din} !== {1'b1, 4'b1000, 13'd2, 32'hB2000000}) begin
      n_fail++; $display("FAIL st_split_acc0: en=%b we=%b addr=%0d din=%h want 1 1000 2 b2000000",
                         mem_en, mem_we, mem_addr, mem_din);
    end
    step();
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_din} !== {1'b1, 4'b0001, 13'd3, 32'h000000A1}) begin
      n_fail++; $display("FAIL st_split_acc1: en=%b we=%b addr=%0d din=%h want 1 0001 3 000000a1",
                         mem_en, mem_we, mem_addr, mem_din);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL st_split_early: got %b want 0", rsp_valid);
    end
    step();
    n_checks++;
    if ({rsp_valid, rsp_err} !== 2'b10) begin
      n_fail++; $display("FAIL st_split_rsp: vld=%b err=%b want 1 0", rsp_valid, rsp_err);
    end
    n_checks++;
    if ({mem[2], mem[3]} !== {32'hB2111111, 32'h222222A1}) begin
      n_fail++; $display("FAIL st_split_mem: got %h %h want b2111111 222222a1", mem[2], mem[3]);
    end
  endtask

  task automatic test_split_load();
    @(negedge clk);
    mem[1] = 32'h44332211;
    mem[2] = 32'h88776655;
    issue(1'b0, 32'h06, 2'b10, 1'b0, 32'h0);
    n_checks++;
    if ({mem_en, mem_addr} !== {1'b1, 13'd1}) begin
      n_fail++; $display("FAIL ld_split_acc0: en=%b addr=%0d want 1 1", mem_en, mem_addr);
    end
    step();
    n_checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 4'b0000, 13'd2}) begin
      n_fail++; $display("FAIL ld_split_acc1: en=%b we=%b addr=%0d want 1 0000 2", mem_en, mem_we, mem_addr);
    end
    step();
    step();
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h66554433}) begin
      n_fail++; $display("FAIL ld_split_rsp: vld=%b err=%b rdata=%h want 1 0 66554433",
                         rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_errors();
    logic [31:0] e_addr [2];
    logic [1:0]  e_size [2];
    logic        en_seen;
    e_addr[0] = 32'(4 * RAM_DEPTH - 2); e_size[0] = 2'b10;
    e_addr[1] = 32'h00000000;           e_size[1] = 2'b11;
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, e_addr[i], e_size[i], 1'b0, 32'h0);
      en_seen = mem_en;
      step();
      en_seen = en_seen | mem_en;
      n_checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin
        n_fail++; $display("FAIL err_rsp case=%0d: vld=%b err=%b rdata=%h want 1 1 0",
                           i, rsp_valid, rsp_err, rsp_rdata);
      end
      step();
      en_seen = en_seen | mem_en;
      n_checks++;
      if (en_seen !== 1'b0) begin
        n_fail++; $display("FAIL err_no_mem_en case=%0d: got %b want 0", i, en_seen);
      end
    end
    @(negedge clk);
    mem[RAM_DEPTH-1] = 32'hCAFEF00D;
    issue(1'b0, 32'(4 * RAM_DEPTH - 4), 2'b10, 1'b0, 32'h0);
    n_checks++;
    if ({mem_en, mem_addr} !== {1'b1, 13'(RAM_DEPTH - 1)}) begin
      n_fail++; $display("FAIL top_word_acc0: en=%b addr=%0d want 1 %0d", mem_en, mem_addr, RAM_DEPTH - 1);
    end
    step();
    step();
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      n_fail++; $display("FAIL top_word_rsp: vld=%b err=%b rdata=%h want 1 0 cafef00d",
                         rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    mem[4] = 32'h0BADF00D;
    mem[8] = 32'h0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10;
    req_uns = 1'b0; req_wdata = 32'h0;
    step();
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h5A5A5A5A;
    n_checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 4'b0000, 13'd4}) begin
      n_fail++; $display("FAIL b2b_busy_inputs: en=%b we=%b addr=%0d want 1 0000 4", mem_en, mem_we, mem_addr);
    end
    step();
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ready_resp: got %b want 0", req_ready);
    end
    step();
    n_checks++;
    if ({rsp_valid, rsp_rdata, req_ready} !== {1'b1, 32'h0BADF00D, 1'b1}) begin
      n_fail++; $display("FAIL b2b_first_rsp: vld=%b rdata=%h rdy=%b want 1 0badf00d 1",
                         rsp_valid, rsp_rdata, req_ready);
    end
    step();
    req_valid = 1'b0;
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_din} !== {1'b1, 4'b1111, 13'd8, 32'h5A5A5A5A}) begin
      n_fail++; $display("FAIL b2b_second_acc0: en=%b we=%b addr=%0d din=%h want 1 1111 8 5a5a5a5a",
                         mem_en, mem_we, mem_addr, mem_din);
    end
    step();
    step();
    n_checks++;
    if ({rsp_valid, mem[8]} !== {1'b1, 32'h5A5A5A5A}) begin
      n_fail++; $display("FAIL b2b_second_rsp: vld=%b mem8=%h want 1 5a5a5a5a", rsp_valid, mem[8]);
    end
  endtask

  task automatic test_reset_mid();
    logic vld_seen;
    @(negedge clk);
    mem[10] = 32'h0;
    mem[11] = 32'h0;
    issue(1'b1, 32'h2A, 2'b10, 1'b0, 32'h12345678);
    n_checks++;
    if ({mem_we, mem_addr, mem_din} !== {4'b1100, 13'd10, 32'h56780000}) begin
      n_fail++; $display("FAIL rst_mid_acc0: we=%b addr=%0d din=%h want 1100 10 56780000",
                         mem_we, mem_addr, mem_din);
    end
    step();
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_din} !== {1'b1, 4'b0011, 13'd11, 32'h00001234}) begin
      n_fail++; $display("FAIL rst_mid_acc1: en=%b we=%b addr=%0d din=%h want 1 0011 11 00001234",
                         mem_en, mem_we, mem_addr, mem_din);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_en, req_ready} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_gate: en=%b rdy=%b want 0 0", mem_en, req_ready);
    end
    vld_seen = 1'b0;
    repeat (3) begin
      step();
      vld_seen = vld_seen | rsp_valid;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_ready: got %b want 1", req_ready);
    end
    repeat (3) begin
      step();
      vld_seen = vld_seen | rsp_valid;
    end
    n_checks++;
    if (vld_seen !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_no_rsp: got %b want 0", vld_seen);
    end
    n_checks++;
    if ({mem[10], mem[11]} !== {32'h56780000, 32'h0}) begin
      n_fail++; $display("FAIL rst_mid_mem: got %h %h want 56780000 00000000", mem[10], mem[11]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 2'b00;
    req_uns = 1'b0; req_wdata = 32'h0;
    for (int i = 0; i < RAM_DEPTH; i++) mem[i] = 32'h0;
    test_reset();
    test_aligned_store();
    test_byte_load();
    test_split_store();
    test_split_load();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
